// File: rtl/ctrl_defs.sv
// Shared definitions for the multicycle control path: opcodes, ALU op codes,
// FSM state encoding and the decoded-instruction record.
package ctrl_defs;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_SR  = 3'b101;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_SRL = 4'b1000,
        ALU_SLL = 4'b1001,
        ALU_SRA = 4'b1010,
        ALU_XOR = 4'b1101
    } alu_op_e;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_e;

    typedef struct packed {
        alu_op_e alu_ctrl;
        logic    alu_src;
        logic    is_load;
        logic    is_store;
        logic    is_branch;
        logic    writes_reg;
        logic    illegal;
    } dec_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational RV32I-subset decoder: instr -> ALU op, operand select and
// instruction class flags. Anything outside the supported subset is illegal.
module instr_decoder
    import ctrl_defs::*;
(
    input  logic [31:0] instr,
    output dec_t        dec
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       f7_base, f7_alt;
    logic       arith_ok, r_f7_ok, i_f7_ok;
    alu_op_e    arith_op;
    logic       unused_fields;

    assign opcode  = instr[6:0];
    assign funct3  = instr[14:12];
    assign funct7  = instr[31:25];
    assign f7_base = (funct7 == F7_BASE);
    assign f7_alt  = (funct7 == F7_ALT);
    assign unused_fields = ^{instr[24:15], instr[11:7]};

    // R-type only allows the alternate funct7 for SUB/SRA; I-type only checks it on shifts.
    assign r_f7_ok = f7_base || (f7_alt && (funct3 == F3_ADD || funct3 == F3_SR));
    assign i_f7_ok = (funct3 == F3_SLL) ? f7_base :
                     (funct3 == F3_SR)  ? (f7_base || f7_alt) : 1'b1;

    always_comb begin
        arith_op = ALU_ADD;
        arith_ok = 1'b1;
        case (funct3)
            F3_ADD:  arith_op = ALU_ADD;
            F3_SLL:  arith_op = ALU_SLL;
            F3_SLT:  arith_op = ALU_SLT;
            F3_XOR:  arith_op = ALU_XOR;
            F3_SR:   arith_op = funct7[5] ? ALU_SRA : ALU_SRL;
            F3_OR:   arith_op = ALU_OR;
            F3_AND:  arith_op = ALU_AND;
            default: arith_ok = 1'b0;
        endcase
    end

    always_comb begin
        dec          = '0;
        dec.alu_ctrl = ALU_AND;
        dec.illegal  = 1'b1;
        case (opcode)
            OP_R: if (arith_ok && r_f7_ok) begin
                dec.alu_ctrl   = (funct3 == F3_ADD && f7_alt) ? ALU_SUB : arith_op;
                dec.writes_reg = 1'b1;
                dec.illegal    = 1'b0;
            end
            OP_I: if (arith_ok && i_f7_ok) begin
                dec.alu_ctrl   = arith_op;
                dec.alu_src    = 1'b1;
                dec.writes_reg = 1'b1;
                dec.illegal    = 1'b0;
            end
            OP_LW: if (funct3 == F3_W) begin
                dec.alu_ctrl   = ALU_ADD;
                dec.alu_src    = 1'b1;
                dec.is_load    = 1'b1;
                dec.writes_reg = 1'b1;
                dec.illegal    = 1'b0;
            end
            OP_SW: if (funct3 == F3_W) begin
                dec.alu_ctrl = ALU_ADD;
                dec.alu_src  = 1'b1;
                dec.is_store = 1'b1;
                dec.illegal  = 1'b0;
            end
            OP_BEQ: if (funct3 == F3_BEQ) begin
                dec.alu_ctrl  = ALU_SUB;
                dec.is_branch = 1'b1;
                dec.illegal   = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: IF/ID/EX/(MEM)/WB sequencing, data-memory handshake
// with timeout, and retired-instruction counter. All outputs are registered.
module multicycle_ctrl
    import ctrl_defs::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        Zero,
    input  logic        dReady,
    output logic        PCSrc,
    output logic        ALUSrc,
    output logic        RegWrite,
    output logic        MemToReg,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        loadPC,
    output logic [3:0]  ALUCtrl,
    output logic        illegal_instr,
    output logic        mem_err,
    output logic [31:0] instr_retired
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    state_e        state;
    dec_t          dec, dec_q;
    logic [CW-1:0] wait_cnt;
    logic          mem_op, wait_last, enter_wb, mem_fail;

    instr_decoder u_dec (
        .instr (instr),
        .dec   (dec)
    );

    // Decode is held in dec_q from ID through WB, so these stay registered.
    assign ALUCtrl = dec_q.alu_ctrl;
    assign ALUSrc  = dec_q.alu_src;

    assign mem_op    = dec_q.is_load | dec_q.is_store;
    assign wait_last = (wait_cnt == CW'(MEM_TIMEOUT - 1));
    assign enter_wb  = (state == S_EX && !mem_op) ||
                       (state == S_MEM && (dReady || wait_last));
    assign mem_fail  = (state == S_MEM) && !dReady;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= S_IF;
            dec_q         <= '0;
            wait_cnt      <= '0;
            PCSrc         <= 1'b0;
            RegWrite      <= 1'b0;
            MemToReg      <= 1'b0;
            MemRead       <= 1'b0;
            MemWrite      <= 1'b0;
            loadPC        <= 1'b0;
            illegal_instr <= 1'b0;
            mem_err       <= 1'b0;
            instr_retired <= '0;
        end else begin
            PCSrc         <= 1'b0;
            RegWrite      <= 1'b0;
            MemToReg      <= 1'b0;
            loadPC        <= 1'b0;
            illegal_instr <= 1'b0;
            mem_err       <= 1'b0;

            case (state)
                S_IF: begin
                    dec_q <= dec;
                    state <= S_ID;
                end
                S_ID: state <= S_EX;
                S_EX: begin
                    if (mem_op) begin
                        MemRead  <= dec_q.is_load;
                        MemWrite <= dec_q.is_store;
                        wait_cnt <= '0;
                        state    <= S_MEM;
                    end else begin
                        state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dReady || wait_last) begin
                        MemRead  <= 1'b0;
                        MemWrite <= 1'b0;
                        state    <= S_WB;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                S_WB: begin
                    dec_q <= '0;
                    state <= S_IF;
                end
                default: state <= S_IF;
            endcase

            // Writeback pulses are launched on the edge into WB so they appear during WB.
            if (enter_wb) begin
                loadPC        <= 1'b1;
                PCSrc         <= dec_q.is_branch & Zero;
                RegWrite      <= dec_q.writes_reg & ~mem_fail;
                MemToReg      <= dec_q.is_load & ~mem_fail;
                illegal_instr <= dec_q.illegal;
                mem_err       <= mem_fail;
                if (!dec_q.illegal && !mem_fail)
                    instr_retired <= instr_retired + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: directed spec cases, randomized
// instruction stream, and mid-instruction reset.
module tb_multicycle_ctrl;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] instr = '0;
    logic        Zero = 1'b0;
    logic        dReady = 1'b0;
    logic        PCSrc, ALUSrc, RegWrite, MemToReg, MemRead, MemWrite, loadPC;
    logic [3:0]  ALUCtrl;
    logic        illegal_instr, mem_err;
    logic [31:0] instr_retired;

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_TIMEOUT(T)) dut (
        .clk           (clk),
        .rst           (rst),
        .instr         (instr),
        .Zero          (Zero),
        .dReady        (dReady),
        .PCSrc         (PCSrc),
        .ALUSrc        (ALUSrc),
        .RegWrite      (RegWrite),
        .MemToReg      (MemToReg),
        .MemRead       (MemRead),
        .MemWrite      (MemWrite),
        .loadPC        (loadPC),
        .ALUCtrl       (ALUCtrl),
        .illegal_instr (illegal_instr),
        .mem_err       (mem_err),
        .instr_retired (instr_retired)
    );

    typedef enum int {K_R, K_I, K_LD, K_ST, K_BR} kind_e;
    typedef struct {
        logic [31:0] mask;
        logic [31:0] match;
        logic [3:0]  alu;
        kind_e       kind;
    } pat_t;
    typedef struct {
        logic [3:0]  alu;
        logic        src, rw, m2r, pcs, ill, merr;
        logic [31:0] ret;
        int          len, nrd, nwr;
    } exp_t;

    pat_t        pats[$];
    exp_t        sb[$];
    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] ret_model = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] op);
        return {f7, 10'b0, f3, 5'b0, op};
    endfunction

    task automatic addp(input logic [31:0] mask, input logic [31:0] match, input logic [3:0] alu, input kind_e k);
        pat_t p;
        p.mask = mask; p.match = match; p.alu = alu; p.kind = k;
        pats.push_back(p);
    endtask

    // Legal instruction set as mask/match patterns; first hit wins.
    task automatic build_table();
        addp(32'hFE00707F, mk(7'h00, 3'b000, 7'h33), 4'b0010, K_R);
        addp(32'hFE00707F, mk(7'h20, 3'b000, 7'h33), 4'b0110, K_R);
        addp(32'hFE00707F, mk(7'h00, 3'b111, 7'h33), 4'b0000, K_R);
        addp(32'hFE00707F, mk(7'h00, 3'b110, 7'h33), 4'b0001, K_R);
        addp(32'hFE00707F, mk(7'h00, 3'b100, 7'h33), 4'b1101, K_R);
        addp(32'hFE00707F, mk(7'h00, 3'b010, 7'h33), 4'b0111, K_R);
        addp(32'hFE00707F, mk(7'h00, 3'b001, 7'h33), 4'b1001, K_R);
        addp(32'hFE00707F, mk(7'h00, 3'b101, 7'h33), 4'b1000, K_R);
        addp(32'hFE00707F, mk(7'h20, 3'b101, 7'h33), 4'b1010, K_R);
        addp(32'h0000707F, mk(7'h00, 3'b000, 7'h13), 4'b0010, K_I);
        addp(32'h0000707F, mk(7'h00, 3'b111, 7'h13), 4'b0000, K_I);
        addp(32'h0000707F, mk(7'h00, 3'b110, 7'h13), 4'b0001, K_I);
        addp(32'h0000707F, mk(7'h00, 3'b100, 7'h13), 4'b1101, K_I);
        addp(32'h0000707F, mk(7'h00, 3'b010, 7'h13), 4'b0111, K_I);
        addp(32'hFE00707F, mk(7'h00, 3'b001, 7'h13), 4'b1001, K_I);
        addp(32'hFE00707F, mk(7'h00, 3'b101, 7'h13), 4'b1000, K_I);
        addp(32'hFE00707F, mk(7'h20, 3'b101, 7'h13), 4'b1010, K_I);
        addp(32'h0000707F, mk(7'h00, 3'b010, 7'h03), 4'b0010, K_LD);
        addp(32'h0000707F, mk(7'h00, 3'b010, 7'h23), 4'b0010, K_ST);
        addp(32'h0000707F, mk(7'h00, 3'b000, 7'h63), 4'b0110, K_BR);
    endtask

    function automatic bit lookup(input logic [31:0] ins, output logic [3:0] alu, output kind_e k);
        alu = 4'b0000;
        k   = K_R;
        foreach (pats[i]) begin
            if ((ins & pats[i].mask) == pats[i].match) begin
                alu = pats[i].alu;
                k   = pats[i].kind;
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    // k = MEM cycle on which dReady rises; k > T means it never rises in time.
    task automatic run_instr(input logic [31:0] ins, input logic z, input int k);
        exp_t        e;
        logic [3:0]  alu;
        kind_e       kd;
        bit          legal, mem, err;
        int          m;
        legal = lookup(ins, alu, kd);
        mem   = legal && (kd == K_LD || kd == K_ST);
        m     = mem ? ((k < T) ? k : T) : 0;
        err   = mem && (k > T);
        e.alu  = alu;
        e.src  = legal && (kd == K_I || kd == K_LD || kd == K_ST);
        e.rw   = legal && (kd == K_R || kd == K_I || kd == K_LD) && !err;
        e.m2r  = legal && kd == K_LD && !err;
        e.pcs  = legal && kd == K_BR && z;
        e.ill  = !legal;
        e.merr = err;
        if (legal && !err) ret_model = ret_model + 32'd1;
        e.ret  = ret_model;
        e.len  = 4 + m;
        e.nrd  = (legal && kd == K_LD) ? m : 0;
        e.nwr  = (legal && kd == K_ST) ? m : 0;
        sb.push_back(e);

        instr = ins;
        Zero  = z;
        for (int c = 1; c <= e.len; c++) begin
            if (mem && c > 3 && c < e.len)
                dReady = (c == 3 + k);
            else
                dReady = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        dReady = 1'b0;
    endtask

    // Monitor: one record popped per loadPC pulse.
    int          mon_cyc = 0;
    int          mon_rd = 0;
    int          mon_wr = 0;
    logic [3:0]  id_alu = '0;
    logic        id_src = 1'b0;
    exp_t        me;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                mon_cyc = 0; mon_rd = 0; mon_wr = 0;
            end else begin
                mon_cyc++;
                mon_rd += int'(MemRead);
                mon_wr += int'(MemWrite);
                if (mon_cyc == 2) begin
                    id_alu = ALUCtrl;
                    id_src = ALUSrc;
                end
                if (loadPC) begin
                    if (sb.size() == 0) begin
                        n_vec++; n_bad++;
                        $display("FAIL unexpected_wb: got loadPC=1 expected no writeback at %0t", $time);
                    end else begin
                        me = sb.pop_front();
                        chk("alu_ctrl_id", 32'(id_alu), 32'(me.alu));
                        chk("alu_src_id", 32'(id_src), 32'(me.src));
                        chk("alu_ctrl_wb", 32'(ALUCtrl), 32'(me.alu));
                        chk("alu_src_wb", 32'(ALUSrc), 32'(me.src));
                        chk("reg_write", 32'(RegWrite), 32'(me.rw));
                        chk("mem_to_reg", 32'(MemToReg), 32'(me.m2r));
                        chk("pc_src", 32'(PCSrc), 32'(me.pcs));
                        chk("illegal_instr", 32'(illegal_instr), 32'(me.ill));
                        chk("mem_err", 32'(mem_err), 32'(me.merr));
                        chk("instr_retired", instr_retired, me.ret);
                        chk("instr_cycles", 32'(mon_cyc), 32'(me.len));
                        chk("mem_read_cycles", 32'(mon_rd), 32'(me.nrd));
                        chk("mem_write_cycles", 32'(mon_wr), 32'(me.nwr));
                        chk("strobe_in_wb", 32'({MemRead, MemWrite}), 32'd0);
                    end
                    mon_cyc = 0; mon_rd = 0; mon_wr = 0;
                end else if (mon_cyc > 3 * T) begin
                    n_vec++; n_bad++;
                    $display("FAIL wb_timeout: got no loadPC in %0d cycles expected one", mon_cyc);
                    mon_cyc = 0; mon_rd = 0; mon_wr = 0;
                end
            end
        end
    end

    initial begin
        logic [31:0] ins;
        pat_t        p;
        int          r;
        build_table();

        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 32'({PCSrc, ALUSrc, RegWrite, MemToReg, MemRead, MemWrite,
                                  loadPC, ALUCtrl, illegal_instr, mem_err}), 32'd0);
        chk("reset_retired", instr_retired, 32'd0);
        rst = 1'b1;

        run_instr(32'h002081B3, 1'b0, 0);       // ADD
        run_instr(32'h00802283, 1'b0, 3);       // LW, ready on 3rd MEM cycle
        run_instr(32'h00502623, 1'b0, T + 20);  // SW, never ready
        run_instr(32'h00000463, 1'b1, 0);       // BEQ taken
        run_instr(32'h00000463, 1'b0, 0);       // BEQ not taken
        run_instr(32'hFFFFFFFF, 1'b0, 0);       // illegal
        run_instr(32'h402081B3, 1'b0, 0);       // SUB
        run_instr(32'h00802283, 1'b0, T);       // LW, ready on last allowed cycle
        run_instr(32'h00802283, 1'b0, 1);       // LW, immediate ready
        run_instr(32'h00502623, 1'b0, T + 1);   // SW, one cycle too late
        run_instr(32'h00502623, 1'b1, 5);       // SW ok

        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                ins = $urandom;
            end else begin
                p   = pats[$urandom_range(0, pats.size() - 1)];
                ins = ($urandom & ~p.mask) | p.match;
            end
            run_instr(ins, 1'($urandom_range(0, 1)), $urandom_range(1, T + 2));
        end

        // Reset during the second MEM cycle of a LW.
        instr  = 32'h00802283;
        dReady = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        chk("abort_mem_read_active", 32'(MemRead), 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_outputs", 32'({PCSrc, ALUSrc, RegWrite, MemToReg, MemRead, MemWrite,
                                  loadPC, ALUCtrl, illegal_instr, mem_err}), 32'd0);
        chk("abort_retired", instr_retired, 32'd0);
        ret_model = '0;
        rst = 1'b1;
        run_instr(32'h002081B3, 1'b0, 0);
        run_instr(32'h00802283, 1'b0, 2);

        for (int w = 0; w < 100 && sb.size() != 0; w++) @(posedge clk);
        if (sb.size() != 0) begin
            n_vec++; n_bad++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
